// File: rtl/eda_result_reader.sv
// Streams the (i,j) coordinates of every set bit of a snapshotted regional-maximum bitmap.
// Optional EDA_READER_ROW_SKIP_EN: skip all-zero rows in a single scan cycle.
`ifndef CFG_M
`define CFG_M 16
`endif
`ifndef CFG_N
`define CFG_N 16
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 4
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 4
`endif

module eda_result_reader #(
  parameter int unsigned M         = `CFG_M,
  parameter int unsigned N         = `CFG_N,
  parameter int unsigned I_WIDTH   = `CFG_I_WIDTH,
  parameter int unsigned J_WIDTH   = `CFG_J_WIDTH,
  parameter int unsigned CNT_WIDTH = I_WIDTH + J_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    done,
  input  logic [M-1:0][N-1:0]     matrix_output,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [I_WIDTH-1:0]      out_i,
  output logic [J_WIDTH-1:0]      out_j,
  output logic                    out_last,
  output logic                    busy,
  output logic                    frame_done,
  output logic [CNT_WIDTH-1:0]    max_count,
  output logic                    overrun
);

  localparam int unsigned MN = M * N;
  localparam int unsigned PW = I_WIDTH + J_WIDTH;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_e;

  state_e                 state_q, state_d;
  logic                   done_q;
  logic [MN-1:0]          snap_q, snap_d;
  logic [I_WIDTH-1:0]     i_q, i_d, nxt_i;
  logic [J_WIDTH-1:0]     j_q, j_d, nxt_j;
  logic                   out_valid_q, out_valid_d;
  logic [I_WIDTH-1:0]     out_i_q, out_i_d;
  logic [J_WIDTH-1:0]     out_j_q, out_j_d;
  logic                   out_last_q, out_last_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic [CNT_WIDTH-1:0]   max_count_q, max_count_d;
  logic                   overrun_q, overrun_d;

  logic                   start_ev;
  logic [PW-1:0]          pos;
  logic [MN-1:0]          pos_mask;
  logic                   cur_bit;
  logic                   rest_zero;
  logic                   row_end;
  logic                   last_pos;

  // Scan position decode: pos = i*N + j, matching the packed bitmap layout.
  assign start_ev  = done & ~done_q;
  assign pos       = PW'(32'(i_q) * N + 32'(j_q));
  assign pos_mask  = MN'(1) << pos;
  assign cur_bit   = |(snap_q & pos_mask);
  assign rest_zero = ~|(snap_q & ~pos_mask);
  assign row_end   = (j_q == J_WIDTH'(N - 1));
  assign last_pos  = row_end && (i_q == I_WIDTH'(M - 1));
  assign nxt_i     = row_end ? i_q + 1'b1 : i_q;
  assign nxt_j     = row_end ? '0 : j_q + 1'b1;

`ifdef EDA_READER_ROW_SKIP_EN
  logic [PW-1:0] row_base;
  logic          row_zero;
  assign row_base = PW'(32'(i_q) * N);
  assign row_zero = (j_q == '0) && ~|snap_q[row_base +: N];
`endif

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    i_d          = i_q;
    j_d          = j_q;
    out_valid_d  = out_valid_q;
    out_i_d      = out_i_q;
    out_j_d      = out_j_q;
    out_last_d   = out_last_q;
    max_count_d  = max_count_q;
    overrun_d    = overrun_q;

    if (start_ev && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_ev) begin
          state_d     = SCAN;
          snap_d      = matrix_output;
          max_count_d = '0;
          i_d         = '0;
          j_d         = '0;
        end
      end
      SCAN: begin
        if (cur_bit) begin
          out_valid_d = 1'b1;
          out_i_d     = i_q;
          out_j_d     = j_q;
          out_last_d  = rest_zero;
          state_d     = EMIT;
        end
`ifdef EDA_READER_ROW_SKIP_EN
        else if (row_zero) begin
          if (i_q == I_WIDTH'(M - 1)) begin
            state_d = FIN;
          end else begin
            i_d = i_q + 1'b1;
            j_d = '0;
          end
        end
`endif
        else if (last_pos) begin
          state_d = FIN;
        end else begin
          i_d = nxt_i;
          j_d = nxt_j;
        end
      end
      EMIT: begin
        // (i_q,j_q) still points at the coordinate being offered.
        if (out_ready) begin
          out_valid_d = 1'b0;
          snap_d      = snap_q & ~pos_mask;
          if (max_count_q != '1) max_count_d = max_count_q + 1'b1;
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = FIN;
          end else begin
            i_d     = nxt_i;
            j_d     = nxt_j;
            state_d = SCAN;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      snap_q       <= '0;
      i_q          <= '0;
      j_q          <= '0;
      out_valid_q  <= 1'b0;
      out_i_q      <= '0;
      out_j_q      <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      max_count_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= done;
      snap_q       <= snap_d;
      i_q          <= i_d;
      j_q          <= j_d;
      out_valid_q  <= out_valid_d;
      out_i_q      <= out_i_d;
      out_j_q      <= out_j_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      max_count_q  <= max_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_i      = out_i_q;
  assign out_j      = out_j_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign max_count  = max_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_eda_result_reader.sv
// Self-checking bench for eda_result_reader against a raster-order coordinate model.
`timescale 1ns/1ps
module tb_eda_result_reader;
  localparam int unsigned M = 16;
  localparam int unsigned N = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned JW = 4;
  localparam int unsigned CW = 9;
  localparam int unsigned MN = M * N;
`ifdef EDA_READER_ROW_SKIP_EN
  localparam int EMPTY_LAT = M + 1;
`else
  localparam int EMPTY_LAT = M * N + 1;
`endif
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              reset_n, done, out_ready;
  logic [M-1:0][N-1:0] matrix_output;
  logic              out_valid, out_last, busy, frame_done, overrun;
  logic [IW-1:0]     out_i;
  logic [JW-1:0]     out_j;
  logic [CW-1:0]     max_count;

  int checks = 0;
  int errors = 0;

  int obs_i[$], obs_j[$];
  bit obs_last[$];
  int exp_i[$], exp_j[$];
  int fd_count, fd_first, first_valid, vcount, hold_viol;
  logic busy_at1;

  always #5 clk = ~clk;

  eda_result_reader #(.M(M), .N(N), .I_WIDTH(IW), .J_WIDTH(JW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .done(done), .matrix_output(matrix_output),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_j(out_j),
    .out_last(out_last), .busy(busy), .frame_done(frame_done),
    .max_count(max_count), .overrun(overrun)
  );

  // Reference: every set pixel, row-major, visited as a 2-D image.
  function automatic void model_seq(input logic [MN-1:0] bm);
    logic [M-1:0][N-1:0] img;
    img = bm;
    exp_i.delete();
    exp_j.delete();
    for (int i = 0; i < int'(M); i++)
      for (int j = 0; j < int'(N); j++)
        if (img[i][j]) begin
          exp_i.push_back(i);
          exp_j.push_back(j);
        end
  endfunction

  function automatic logic [MN-1:0] rand_bm(input int dens);
    logic [MN-1:0] b;
    for (int p = 0; p < int'(MN); p++) b[p] = (int'($urandom_range(99)) < dens);
    return b;
  endfunction

  function automatic int sat_count(input int n);
    return (n > 511) ? 511 : n;
  endfunction

  // Raises done with bm, plays the consumer, records coordinates and frame statistics.
  task automatic run_frame(input logic [MN-1:0] bm, input int mode, input bit inject);
    int hs, inj;
    bit stall;
    logic [IW-1:0] pi;
    logic [JW-1:0] pj;
    logic pl, r;
    obs_i.delete(); obs_j.delete(); obs_last.delete();
    fd_count = 0; fd_first = -1; first_valid = -1; vcount = 0; hold_viol = 0;
    hs = 0; inj = 0; stall = 1'b0; pi = '0; pj = '0; pl = 1'b0; busy_at1 = 1'b0;
    matrix_output = bm;
    done = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (c == 1) busy_at1 = busy;
      if (c == 2) begin done = 1'b0; matrix_output = rand_bm(50); end
      if (inj == 1) begin done = 1'b0; inj = 2; end
      if (frame_done === 1'b1) begin
        fd_count++;
        if (fd_first < 0) fd_first = c;
      end
      if (stall && (out_valid !== 1'b1 || out_i !== pi || out_j !== pj || out_last !== pl))
        hold_viol++;
      case (mode)
        1: r = c[0];
        2: r = 1'($urandom_range(1));
        3: r = (vcount >= 10);
        default: r = 1'b1;
      endcase
      if (out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        vcount++;
        if (r) begin
          obs_i.push_back(int'(out_i));
          obs_j.push_back(int'(out_j));
          obs_last.push_back(out_last);
          hs++;
        end
      end
      out_ready = r;
      stall = (out_valid === 1'b1) && !r;
      pi = out_i; pj = out_j; pl = out_last;
      if (inject && inj == 0 && hs == 10) begin
        done = 1'b1;
        matrix_output = ~bm;
        inj = 1;
      end
      if (fd_first >= 0 && c >= fd_first + 3) break;
    end
    done = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [23:0] v;
    reset_n = 1'b0; done = 1'b0; out_ready = 1'b0; matrix_output = '0;
    repeat (3) @(posedge clk);
    #1;
    v = {out_valid, 4'(out_i), 4'(out_j), out_last, busy, frame_done, 9'(max_count), overrun, 2'b00};
    checks++;
    if (v !== 24'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", v); end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b out_valid=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_three_points;
    logic [MN-1:0] bm;
    bm = '0; bm[0] = 1'b1; bm[3*16+5] = 1'b1; bm[255] = 1'b1;
    run_frame(bm, 0, 1'b0);
    model_seq(bm);
    checks++;
    if (obs_i.size() !== 3) begin errors++; $display("FAIL three_len: got %0d expected 3", obs_i.size()); end
    for (int k = 0; k < obs_i.size() && k < exp_i.size(); k++) begin
      checks++;
      if (obs_i[k] !== exp_i[k] || obs_j[k] !== exp_j[k] || obs_last[k] !== (k == exp_i.size() - 1)) begin
        errors++;
        $display("FAIL three_coord[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", k,
                 obs_i[k], obs_j[k], obs_last[k], exp_i[k], exp_j[k], k == exp_i.size() - 1);
      end
    end
    checks++;
    if (max_count !== 9'd3) begin errors++; $display("FAIL three_count: got %0d expected 3", max_count); end
    checks++;
    if (fd_count !== 1) begin errors++; $display("FAIL three_frame_done: got %0d pulses expected 1", fd_count); end
    checks++;
    if (first_valid !== 2) begin errors++; $display("FAIL three_latency: got %0d expected 2", first_valid); end
    checks++;
    if (busy_at1 !== 1'b1) begin errors++; $display("FAIL three_busy: got %b expected 1", busy_at1); end
  endtask

  task automatic test_empty;
    run_frame('0, 0, 1'b0);
    checks++;
    if (first_valid !== -1) begin errors++; $display("FAIL empty_valid: valid at cycle %0d expected never", first_valid); end
    checks++;
    if (fd_first !== EMPTY_LAT) begin errors++; $display("FAIL empty_latency: got %0d expected %0d", fd_first, EMPTY_LAT); end
    checks++;
    if (fd_count !== 1) begin errors++; $display("FAIL empty_frame_done: got %0d pulses expected 1", fd_count); end
    checks++;
    if (max_count !== 9'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", max_count); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stall;
    logic [MN-1:0] bm;
    bm = '0; bm[2*16+7] = 1'b1;
    run_frame(bm, 3, 1'b0);
    checks++;
    if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d violations expected 0", hold_viol); end
    checks++;
    if (vcount !== 11) begin errors++; $display("FAIL stall_valid_cycles: got %0d expected 11", vcount); end
    checks++;
    if (obs_i.size() !== 1) begin
      errors++; $display("FAIL stall_len: got %0d expected 1", obs_i.size());
    end else if (obs_i[0] !== 2 || obs_j[0] !== 7 || obs_last[0] !== 1'b1) begin
      errors++; $display("FAIL stall_coord: got (%0d,%0d,%0d) expected (2,7,1)", obs_i[0], obs_j[0], obs_last[0]);
    end
  endtask

  task automatic test_overrun;
    logic [MN-1:0] bm;
    int cnt;
    bm = '0; cnt = 0;
    while (cnt < 40) begin
      int p;
      p = int'($urandom_range(MN - 1));
      if (!bm[p]) begin bm[p] = 1'b1; cnt++; end
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b expected 0", overrun); end
    run_frame(bm, 0, 1'b1);
    model_seq(bm);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
    checks++;
    if (obs_i.size() !== 40) begin errors++; $display("FAIL overrun_len: got %0d expected 40", obs_i.size()); end
    for (int k = 0; k < obs_i.size() && k < exp_i.size(); k++) begin
      checks++;
      if (obs_i[k] !== exp_i[k] || obs_j[k] !== exp_j[k] || obs_last[k] !== (k == exp_i.size() - 1)) begin
        errors++;
        $display("FAIL overrun_coord[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", k,
                 obs_i[k], obs_j[k], obs_last[k], exp_i[k], exp_j[k], k == exp_i.size() - 1);
      end
    end
    checks++;
    if (max_count !== 9'd40) begin errors++; $display("FAIL overrun_count: got %0d expected 40", max_count); end
    checks++;
    if (fd_count !== 1) begin errors++; $display("FAIL overrun_frame_done: got %0d pulses expected 1", fd_count); end
  endtask

  task automatic test_reset_mid;
    logic [MN-1:0] bm;
    logic [23:0] v;
    bit seen;
    bm = rand_bm(20); bm[1*16+4] = 1'b1;
    matrix_output = bm; done = 1'b1; out_ready = 1'b0; seen = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (c == 2) done = 1'b0;
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
    end
    done = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_valid: got no out_valid expected one within 400 cycles"); end
    #2 reset_n = 1'b0;
    #1;
    v = {out_valid, 4'(out_i), 4'(out_j), out_last, busy, frame_done, 9'(max_count), overrun, 2'b00};
    checks++;
    if (v !== 24'h0) begin errors++; $display("FAIL rstmid_outputs: got %h expected 0", v); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    bm = '0; bm[1*16+1] = 1'b1;
    run_frame(bm, 0, 1'b0);
    checks++;
    if (obs_i.size() !== 1) begin
      errors++; $display("FAIL rstmid_len: got %0d expected 1", obs_i.size());
    end else if (obs_i[0] !== 1 || obs_j[0] !== 1 || obs_last[0] !== 1'b1) begin
      errors++; $display("FAIL rstmid_coord: got (%0d,%0d,%0d) expected (1,1,1)", obs_i[0], obs_j[0], obs_last[0]);
    end
  endtask

  task automatic test_full;
    run_frame('1, 1, 1'b0);
    model_seq('1);
    checks++;
    if (obs_i.size() !== 256) begin errors++; $display("FAIL full_len: got %0d expected 256", obs_i.size()); end
    for (int k = 0; k < obs_i.size() && k < exp_i.size(); k++) begin
      checks++;
      if (obs_i[k] !== exp_i[k] || obs_j[k] !== exp_j[k] || obs_last[k] !== (k == exp_i.size() - 1)) begin
        errors++;
        $display("FAIL full_coord[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", k,
                 obs_i[k], obs_j[k], obs_last[k], exp_i[k], exp_j[k], k == exp_i.size() - 1);
      end
    end
    checks++;
    if (max_count !== 9'd256) begin errors++; $display("FAIL full_count: got %0d expected 256", max_count); end
    checks++;
    if (hold_viol !== 0) begin errors++; $display("FAIL full_hold: got %0d violations expected 0", hold_viol); end
  endtask

  task automatic test_random;
    logic [MN-1:0] bm;
    int dens[3] = '{5, 30, 80};
    for (int f = 0; f < 3; f++) begin
      bm = rand_bm(dens[f]);
      run_frame(bm, 2, 1'b0);
      model_seq(bm);
      checks++;
      if (obs_i.size() !== exp_i.size()) begin
        errors++; $display("FAIL rand%0d_len: got %0d expected %0d", f, obs_i.size(), exp_i.size());
      end
      for (int k = 0; k < obs_i.size() && k < exp_i.size(); k++) begin
        checks++;
        if (obs_i[k] !== exp_i[k] || obs_j[k] !== exp_j[k] || obs_last[k] !== (k == exp_i.size() - 1)) begin
          errors++;
          $display("FAIL rand%0d_coord[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", f, k,
                   obs_i[k], obs_j[k], obs_last[k], exp_i[k], exp_j[k], k == exp_i.size() - 1);
        end
      end
      checks++;
      if (int'(max_count) !== sat_count(exp_i.size())) begin
        errors++; $display("FAIL rand%0d_count: got %0d expected %0d", f, max_count, sat_count(exp_i.size()));
      end
      checks++;
      if (fd_count !== 1 || hold_viol !== 0) begin
        errors++; $display("FAIL rand%0d_frame: got pulses=%0d holdviol=%0d expected 1 0", f, fd_count, hold_viol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_points();
    test_empty();
    test_stall();
    test_overrun();
    test_reset_mid();
    test_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
